// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg : word width and rotate/shift amounts for the SHA-256 sigmas
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sha256_pkg;

  localparam int unsigned WORD_W = 32;

  localparam int unsigned S0_R1 = 2;
  localparam int unsigned S0_R2 = 13;
  localparam int unsigned S0_R3 = 22;

  localparam int unsigned S1_R1 = 6;
  localparam int unsigned S1_R2 = 11;
  localparam int unsigned S1_R3 = 25;

  localparam int unsigned s0_R1 = 7;
  localparam int unsigned s0_R2 = 18;
  localparam int unsigned s0_SH = 3;

  localparam int unsigned s1_R1 = 17;
  localparam int unsigned s1_R2 = 19;
  localparam int unsigned s1_SH = 10;

endpackage : sha256_pkg

`default_nettype wire

// File: rtl/sha256_rotr.sv
// ---------------------------------------------------------------------------
// sha256_rotr : 32-bit rotate right by a constant N (1..31), pure wiring
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sha256_rotr
  import sha256_pkg::*;
#(
  parameter int unsigned N = 1
) (
  input  logic [WORD_W-1:0] i_x,
  output logic [WORD_W-1:0] o_y
);

  assign o_y = {i_x[N-1:0], i_x[WORD_W-1:N]};

endmodule : sha256_rotr

`default_nettype wire

// File: rtl/sha256_sigma_unit.sv
// ---------------------------------------------------------------------------
// sha256_sigma_unit : SHA-256 big sigma0/1 and small sigma0 on one word,
//                     optionally output-registered, valid-tagged
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sha256_sigma_unit
  import sha256_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] x,
  output logic              out_valid,
  output logic [WORD_W-1:0] big_sigma0,
  output logic [WORD_W-1:0] big_sigma1,
  output logic [WORD_W-1:0] small_sigma0
);

  logic [WORD_W-1:0] w_rb0a, w_rb0b, w_rb0c;
  logic [WORD_W-1:0] w_rb1a, w_rb1b, w_rb1c;
  logic [WORD_W-1:0] w_rs0a, w_rs0b;
  logic [WORD_W-1:0] w_bs0, w_bs1, w_ss0;

  sha256_rotr #(.N(S0_R1)) u_rotr_b0a (.i_x(x), .o_y(w_rb0a));
  sha256_rotr #(.N(S0_R2)) u_rotr_b0b (.i_x(x), .o_y(w_rb0b));
  sha256_rotr #(.N(S0_R3)) u_rotr_b0c (.i_x(x), .o_y(w_rb0c));
  sha256_rotr #(.N(S1_R1)) u_rotr_b1a (.i_x(x), .o_y(w_rb1a));
  sha256_rotr #(.N(S1_R2)) u_rotr_b1b (.i_x(x), .o_y(w_rb1b));
  sha256_rotr #(.N(S1_R3)) u_rotr_b1c (.i_x(x), .o_y(w_rb1c));
  sha256_rotr #(.N(s0_R1)) u_rotr_s0a (.i_x(x), .o_y(w_rs0a));
  sha256_rotr #(.N(s0_R2)) u_rotr_s0b (.i_x(x), .o_y(w_rs0b));

  always_comb begin
    w_bs0 = w_rb0a ^ w_rb0b ^ w_rb0c;
    w_bs1 = w_rb1a ^ w_rb1b ^ w_rb1c;
    w_ss0 = w_rs0a ^ w_rs0b ^ (x >> s0_SH);
  end

  generate
    if (REG_OUT) begin : g_reg
      logic              r_valid;
      logic [WORD_W-1:0] r_bs0, r_bs1, r_ss0;

      // Data registers load only on valid words so an idle x never reaches them.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_bs0   <= '0;
          r_bs1   <= '0;
          r_ss0   <= '0;
        end else begin
          r_valid <= in_valid;
          if (in_valid) begin
            r_bs0 <= w_bs0;
            r_bs1 <= w_bs1;
            r_ss0 <= w_ss0;
          end
        end
      end

      assign out_valid    = r_valid;
      assign big_sigma0   = r_bs0;
      assign big_sigma1   = r_bs1;
      assign small_sigma0 = r_ss0;
    end else begin : g_comb
      logic w_unused;
      assign w_unused     = ^{clk, rst};
      assign out_valid    = in_valid;
      assign big_sigma0   = w_bs0;
      assign big_sigma1   = w_bs1;
      assign small_sigma0 = w_ss0;
    end
  endgenerate

endmodule : sha256_sigma_unit

`default_nettype wire

// File: tb/tb_sha256_sigma_unit.sv
// ---------------------------------------------------------------------------
// tb_sha256_sigma_unit : scoreboard bench for registered and combinational builds
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sha256_sigma_unit;

  typedef struct packed {
    logic [31:0] b0;
    logic [31:0] b1;
    logic [31:0] s0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] x = '0;

  logic        r_ov, c_ov;
  logic [31:0] r_b0, r_b1, r_s0, c_b0, c_b1, c_s0;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  sha256_sigma_unit #(.REG_OUT(1'b1)) u_dut_reg (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x),
    .out_valid(r_ov), .big_sigma0(r_b0), .big_sigma1(r_b1), .small_sigma0(r_s0)
  );

  sha256_sigma_unit #(.REG_OUT(1'b0)) u_dut_comb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x),
    .out_valid(c_ov), .big_sigma0(c_b0), .big_sigma1(c_b1), .small_sigma0(c_s0)
  );

  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction

  function automatic exp_t model(input logic [31:0] v);
    exp_t e;
    e.b0 = rotr(v, 2) ^ rotr(v, 13) ^ rotr(v, 22);
    e.b1 = rotr(v, 6) ^ rotr(v, 11) ^ rotr(v, 25);
    e.s0 = rotr(v, 7) ^ rotr(v, 18) ^ (v >> 3);
    return e;
  endfunction

  // Apply one cycle of stimulus; expected registered results enter the scoreboard here.
  task automatic drive(input logic v, input logic [31:0] w, input logic rs, input exp_t e);
    @(negedge clk);
    in_valid = v;
    x        = w;
    rst      = rs;
    if (rs) sb.delete();
    else if (v) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(1'b1, 32'h0000_3FFF, 1'b1, model(32'h0000_3FFF));
    n_checks++;
    if (r_ov !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", r_ov);
    end
    n_checks++;
    if ({r_b0, r_b1, r_s0} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h want 0 0 0", r_b0, r_b1, r_s0);
    end
    // A word already captured, then reset together with a new valid word.
    drive(1'b1, 32'h0000_0001, 1'b0, model(32'h0000_0001));
    e = sb.pop_front();
    n_checks++;
    if (r_ov !== 1'b1 || r_b0 !== e.b0) begin
      n_fail++; $display("FAIL pre_reset_word: got v=%b %h want v=1 %h", r_ov, r_b0, e.b0);
    end
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, model(32'hFFFF_FFFF));
    n_checks++;
    if (r_ov !== 1'b0 || {r_b0, r_b1, r_s0} !== 96'h0) begin
      n_fail++; $display("FAIL reset_wins: got v=%b %h %h %h want v=0 all 0", r_ov, r_b0, r_b1, r_s0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    exp_t        gold  [4];
    exp_t        e;
    words[0] = 32'h0000_3FFF; gold[0] = '{32'h3F07F3FE, 32'h03FFFF78, 32'hF1FFC780};
    words[1] = 32'h0000_0001; gold[1] = '{32'h40080400, 32'h04200080, 32'h02004000};
    words[2] = 32'hFFFF_FFFF; gold[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1FFFFFFF};
    words[3] = 32'h0000_0000; gold[3] = '{32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, words[i], 1'b0, gold[i]);
      n_checks++;
      if (c_ov !== 1'b1 || {c_b0, c_b1, c_s0} !== gold[i]) begin
        n_fail++; $display("FAIL comb_vec%0d: got v=%b %h %h %h want v=1 %h %h %h",
                           i, c_ov, c_b0, c_b1, c_s0, gold[i].b0, gold[i].b1, gold[i].s0);
      end
      n_checks++;
      if (r_ov !== 1'b1) begin
        n_fail++; $display("FAIL b2b_valid%0d: got %b want 1", i, r_ov);
      end
      e = sb.pop_front();
      n_checks++;
      if ({r_b0, r_b1, r_s0} !== e) begin
        n_fail++; $display("FAIL b2b_data%0d: got %h %h %h want %h %h %h",
                           i, r_b0, r_b1, r_s0, e.b0, e.b1, e.s0);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    drive(1'b1, 32'h0000_3FFF, 1'b0, '{32'h3F07F3FE, 32'h03FFFF78, 32'hF1FFC780});
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, $urandom, 1'b0, '0);
      n_checks++;
      if (r_ov !== 1'b0 || {r_b0, r_b1, r_s0} !== e) begin
        n_fail++; $display("FAIL hold%0d: got v=%b %h %h %h want v=0 %h %h %h",
                           i, r_ov, r_b0, r_b1, r_s0, e.b0, e.b1, e.s0);
      end
      n_checks++;
      if (c_ov !== 1'b0) begin
        n_fail++; $display("FAIL comb_idle_valid%0d: got %b want 0", i, c_ov);
      end
    end
  endtask

  task automatic test_random();
    exp_t        e, ce;
    logic        v;
    logic [31:0] w;
    for (int i = 0; i < 10000; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      w  = $urandom;
      ce = model(w);
      drive(v, w, 1'b0, ce);
      n_checks++;
      if (r_ov !== v) begin
        n_fail++; $display("FAIL rnd_valid%0d: got %b want %b", i, r_ov, v);
      end
      if (v) begin
        e = sb.pop_front();
        n_checks++;
        if ({r_b0, r_b1, r_s0} !== e) begin
          n_fail++; $display("FAIL rnd_reg%0d x=%h: got %h %h %h want %h %h %h",
                             i, w, r_b0, r_b1, r_s0, e.b0, e.b1, e.s0);
        end
        n_checks++;
        if (c_ov !== 1'b1 || {c_b0, c_b1, c_s0} !== ce) begin
          n_fail++; $display("FAIL rnd_comb%0d x=%h: got v=%b %h %h %h want v=1 %h %h %h",
                             i, w, c_ov, c_b0, c_b1, c_s0, ce.b0, ce.b1, ce.s0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hold();
    test_random();
    drive(1'b0, 32'h0, 1'b0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sha256_sigma_unit

`default_nettype wire
